// File: rtl/tick_pkg.sv
// Shared definitions for the tick generator / tick period meter pair.
package tick_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } meter_state_t;

    // Defaults shared with the clock-divider tick generator.
    localparam int TICK_WIDTH      = 16;
    localparam int TICK_LOCK_COUNT = 4;

endpackage

// File: rtl/tick_period_meter_if.sv
// Enable/tick inputs and measurement results of the tick period meter.
interface tick_period_meter_if
    import tick_pkg::*;
#(
    parameter int WIDTH = TICK_WIDTH
);

    logic             en;
    logic             tick_in;
    logic [WIDTH-1:0] N_out;
    logic             valid;
    logic             locked;
    logic             overflow;

    modport master (
        output en,
        output tick_in,
        input  N_out,
        input  valid,
        input  locked,
        input  overflow
    );

    modport slave (
        input  en,
        input  tick_in,
        output N_out,
        output valid,
        output locked,
        output overflow
    );

endinterface

// File: rtl/tick_lock_tracker.sv
// Counts consecutive identical measurements and raises locked after LOCK_COUNT of them.
module tick_lock_tracker
    import tick_pkg::*;
#(
    parameter int WIDTH      = TICK_WIDTH,
    parameter int LOCK_COUNT = TICK_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas,
    input  logic             clear,
    input  logic [WIDTH-1:0] new_val,
    input  logic [WIDTH-1:0] prev_val,
    output logic             locked
);

    localparam logic [7:0] LOCK_MAX = 8'(LOCK_COUNT);

    logic [7:0] match_cnt_reg;
    logic [7:0] match_cnt_next;
    logic       locked_reg;
    logic       locked_next;

    always_comb begin
        match_cnt_next = match_cnt_reg;
        locked_next    = locked_reg;
        if (clear) begin
            match_cnt_next = 8'd0;
            locked_next    = 1'b0;
        end else if (meas) begin
            // A zero count means no valid previous value to compare against.
            if (match_cnt_reg == 8'd0 || new_val != prev_val) begin
                match_cnt_next = 8'd1;
            end else if (match_cnt_reg >= LOCK_MAX) begin
                match_cnt_next = LOCK_MAX;
            end else begin
                match_cnt_next = match_cnt_reg + 8'd1;
            end
            locked_next = (match_cnt_next == LOCK_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt_reg <= 8'd0;
            locked_reg    <= 1'b0;
        end else begin
            match_cnt_reg <= match_cnt_next;
            locked_reg    <= locked_next;
        end
    end

    assign locked = locked_reg;

endmodule

// File: rtl/tick_period_meter.sv
// Measures enabled-cycle spacing between tick pulses and recovers the divider setting N.
module tick_period_meter
    import tick_pkg::*;
#(
    parameter int WIDTH      = TICK_WIDTH,
    parameter int LOCK_COUNT = TICK_LOCK_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    tick_period_meter_if.slave   bus
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    meter_state_t     state_reg;
    meter_state_t     state_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] n_out_reg;
    logic [WIDTH-1:0] n_out_next;
    logic             valid_reg;
    logic             valid_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic             meas_fire;
    logic             lock_clear;
    logic             locked;

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        n_out_next    = n_out_reg;
        valid_next    = 1'b0;
        overflow_next = overflow_reg;
        meas_fire     = 1'b0;
        lock_clear    = 1'b0;
        if (bus.en) begin
            unique case (state_reg)
                IDLE: begin
                    // First tick only establishes the reference point.
                    if (bus.tick_in) begin
                        state_next = RUN;
                        count_next = '0;
                    end
                end
                RUN: begin
                    if (bus.tick_in) begin
                        n_out_next    = count_reg;
                        valid_next    = 1'b1;
                        count_next    = '0;
                        overflow_next = 1'b0;
                        meas_fire     = 1'b1;
                    end else if (count_reg != COUNT_MAX) begin
                        count_next = count_reg + 1'b1;
                    end else begin
                        overflow_next = 1'b1;
                        lock_clear    = 1'b1;
                        state_next    = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            n_out_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            n_out_reg    <= n_out_next;
            valid_reg    <= valid_next;
            overflow_reg <= overflow_next;
        end
    end

    // The tracker compares against n_out_reg before it takes the new value.
    tick_lock_tracker #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock (
        .clk      (clk),
        .rst      (rst),
        .meas     (meas_fire),
        .clear    (lock_clear),
        .new_val  (count_reg),
        .prev_val (n_out_reg),
        .locked   (locked)
    );

    assign bus.N_out    = n_out_reg;
    assign bus.valid    = valid_reg;
    assign bus.locked   = locked;
    assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench for tick_period_meter: a 16-bit and a 4-bit instance see the same stimulus.
module tb_tick_period_meter;

    localparam int LOCK = 4;

    typedef struct {
        int unsigned n;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   ph = 0;

    exp_t q0[$];
    exp_t q1[$];

    int unsigned maxv[2] = '{65535, 15};
    bit          ref_seen[2];
    int unsigned gap[2];
    int unsigned run[2];
    int unsigned nexp[2];
    bit          lk[2];
    bit          ov[2];
    int unsigned nexp_c[2];
    bit          lock_c[2];
    bit          ovf_c[2];

    tick_period_meter_if #(.WIDTH(16)) bus ();
    tick_period_meter_if #(.WIDTH(4))  bus4 ();

    tick_period_meter #(.WIDTH(16), .LOCK_COUNT(LOCK)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    tick_period_meter #(.WIDTH(4), .LOCK_COUNT(LOCK)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ref_seen[i] = 0;
            gap[i]      = 0;
            run[i]      = 0;
            nexp[i]     = 0;
            lk[i]       = 0;
            ov[i]       = 0;
            nexp_c[i]   = 0;
            lock_c[i]   = 0;
            ovf_c[i]    = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Drive one cycle of stimulus; model results become visible after the edge.
    task automatic step(input logic e, input logic t);
        bit          pend[2];
        int unsigned pn[2];
        exp_t        x;
        bus.en  = e;
        bus.tick_in  = t;
        bus4.en = e;
        bus4.tick_in = t;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0;
            pn[i]   = 0;
            if (rst && e) begin
                if (!ref_seen[i]) begin
                    if (t) begin
                        ref_seen[i] = 1;
                        gap[i]      = 0;
                    end
                end else if (t) begin
                    pend[i] = 1;
                    pn[i]   = gap[i];
                    if (run[i] != 0 && gap[i] == nexp[i]) begin
                        if (run[i] < LOCK) run[i]++;
                    end else begin
                        run[i] = 1;
                    end
                    nexp[i] = gap[i];
                    lk[i]   = (run[i] >= LOCK);
                    ov[i]   = 0;
                    gap[i]  = 0;
                end else if (gap[i] == maxv[i]) begin
                    ov[i]       = 1;
                    lk[i]       = 0;
                    run[i]      = 0;
                    ref_seen[i] = 0;
                end else begin
                    gap[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            nexp_c[i] = nexp[i];
            lock_c[i] = lk[i];
            ovf_c[i]  = ov[i];
            if (pend[i]) begin
                x.n   = pn[i];
                x.due = cyc;
                if (i == 0) q0.push_back(x);
                else        q1.push_back(x);
            end
        end
        if (pend[0] || pend[1])
            $display("tick  cycle %0d  w16 N=%0d  w4 N=%0d", cyc, pn[0], pn[1]);
    endtask

    // Divider loopback: a tick every n+1 enabled cycles; tick_in is random noise while en=0.
    task automatic run_div(input int n, input int cycles, input bit toggle_en);
        logic e;
        logic t;
        e = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            if (toggle_en) e = (k % 2 == 0);
            if (e) begin
                t  = (ph == 0);
                ph = (ph >= n) ? 0 : ph + 1;
            end else begin
                t = 1'($urandom_range(0, 1));
            end
            step(e, t);
        end
    endtask

    task automatic mon_inst(input int i, input logic v, input logic [31:0] n,
                            input logic lkd, input logic ovf);
        exp_t  e;
        bit    have;
        string pre;
        pre  = (i == 0) ? "w16" : "w4";
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (i == 0) ? q0[0] : q1[0];
        if (v) begin
            if (!have) begin
                check_val({pre, ".spurious_valid"}, 32'(v), 32'd0);
            end else begin
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                check_val({pre, ".n_meas"}, n, e.n);
                check_val({pre, ".latency"}, cyc, e.due);
            end
        end else if (have && e.due <= cyc) begin
            check_val({pre, ".missing_valid"}, 32'(v), 32'd1);
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
        check_val({pre, ".n_out"}, n, nexp_c[i]);
        check_val({pre, ".locked"}, 32'(lkd), 32'(lock_c[i]));
        check_val({pre, ".overflow"}, 32'(ovf), 32'(ovf_c[i]));
    endtask

    always @(negedge clk) begin
        mon_inst(0, bus.valid, 32'(bus.N_out), bus.locked, bus.overflow);
        mon_inst(1, bus4.valid, 32'(bus4.N_out), bus4.locked, bus4.overflow);
    end

    task automatic check_zero_outputs(input string tag);
        check_val({tag, ".n_out"}, 32'(bus.N_out), 32'd0);
        check_val({tag, ".valid"}, 32'(bus.valid), 32'd0);
        check_val({tag, ".locked"}, 32'(bus.locked), 32'd0);
        check_val({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
        check_val({tag, ".w4_n_out"}, 32'(bus4.N_out), 32'd0);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.tick_in = 1'b0;
        bus4.en = 1'b0;
        bus4.tick_in = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        #2 rst = 1'b1;

        // Steady loopback at N=4, then N=0, then N=3 with en toggling.
        ph = 0;
        run_div(4, 40, 1'b0);
        check_val("n4.locked", 32'(bus.locked), 32'd1);
        run_div(0, 12, 1'b0);
        check_val("n0.n_out", 32'(bus.N_out), 32'd0);
        run_div(3, 60, 1'b1);
        check_val("n3.n_out", 32'(bus.N_out), 32'd3);

        // Locked at 7, then retune to 2.
        run_div(7, 48, 1'b0);
        check_val("n7.locked", 32'(bus.locked), 32'd1);
        run_div(2, 30, 1'b0);
        check_val("n2.n_out", 32'(bus.N_out), 32'd2);
        check_val("n2.locked", 32'(bus.locked), 32'd1);

        // One tick then silence: only the 4-bit instance overflows.
        step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        check_val("w4.ovf_set", 32'(bus4.overflow), 32'd1);
        check_val("w16.no_ovf", 32'(bus.overflow), 32'd0);
        ph = 0;
        run_div(5, 30, 1'b0);
        check_val("w4.ovf_clr", 32'(bus4.overflow), 32'd0);
        check_val("w4.n5", 32'(bus4.N_out), 32'd5);

        // Tick exactly at full count is a measurement, not an overflow.
        step(1'b1, 1'b1);
        repeat (15) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check_val("w4.n_max", 32'(bus4.N_out), 32'd15);
        check_val("w4.max_no_ovf", 32'(bus4.overflow), 32'd0);

        // Asynchronous reset with count=3, then re-reference.
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1 check_zero_outputs("midreset");
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        #2 rst = 1'b1;
        step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check_val("post_reset.n", 32'(bus.N_out), 32'd4);

        // Random enable and tick activity.
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("q0.drain", q0.size(), 32'd0);
        check_val("q1.drain", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
